demux16_collector: RTL



---
 rtl/demux16_collector.sv | 52 +++++
 1 files changed

// File: rtl/demux16_collector.sv
// demux16_collector: steers serial bits into a WIDTH-bit word by index and hands it off once every position is written
module demux16_collector #(
  parameter int WIDTH = 16,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             auto_mode,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [SELW-1:0]  sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] written_mask,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;
  logic [WIDTH-1:0] nxt_mask;
  logic accept;
  assign in_ready = state == FILL;
  assign accept = in_valid && in_ready;
  always_comb begin
    idx = auto_mode ? ptr : sel;
    nxt_mask = written_mask | (WIDTH'(1) << idx);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      ptr <= '0;
      out_word <= '0;
      written_mask <= '0;
      out_valid <= 1'b0;
    end else if (clear || (state == HOLD && out_ready)) begin
      state <= FILL;
      ptr <= '0;
      out_word <= '0;
      written_mask <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_word[idx] <= in_bit;
      written_mask <= nxt_mask;
      ptr <= auto_mode ? ptr + 1'b1 : ptr;
      state <= &nxt_mask ? HOLD : FILL;
      out_valid <= &nxt_mask;
    end
  end
endmodule
